// File: rtl/bar0_regs_pkg.sv
// Shared BAR0 register map for the DMA control block: offsets, bit positions
// and the per-channel state type.
package bar0_regs_pkg;

  // Channels occupy 0x000-0x0FF in 32-byte windows; globals sit above that.
  localparam int CH_STRIDE  = 32;
  localparam int CH_IDX_LSB = 5;
  localparam int CH_IDX_W   = 3;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_ADDR_LO = 5'h04;
  localparam logic [4:0] OFF_ADDR_HI = 5'h08;
  localparam logic [4:0] OFF_LEN     = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;

  localparam logic [15:0] REG_IRQ_EN   = 16'h0100;
  localparam logic [15:0] REG_IRQ_STAT = 16'h0104;
  localparam logic [15:0] REG_VERSION  = 16'h0108;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_REJ  = 3;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_state_t;

  function automatic logic in_ch_region(input logic [15:0] addr);
    return addr[15:CH_IDX_LSB+CH_IDX_W] == '0;
  endfunction

  function automatic logic [CH_IDX_W-1:0] ch_index(input logic [15:0] addr);
    return addr[CH_IDX_LSB +: CH_IDX_W];
  endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// One DMA channel: descriptor registers, sticky status bits and the
// IDLE/BUSY sequencer that issues the start pulse to the engine.
module dma_ch_regs
  import bar0_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic        dma_done,
  input  logic        dma_err,
  output logic        dma_start,
  output logic        dma_dir,
  output logic [63:0] dma_addr,
  output logic [31:0] dma_len,
  output logic [3:0]  status,
  output logic        irq_set
);

  ch_state_t state_q, state_nx;
  logic      start_wr;
  logic      cfg_wr;
  logic      stat_wr;
  logic      start_nx;
  logic      rej_set, done_set, err_set;
  logic      done_q, err_q, rej_q;

  assign start_wr = wr_en && (wr_off == OFF_CTRL) && wr_data[CTRL_START];
  // Descriptor fields are frozen while a transfer is in flight.
  assign cfg_wr   = wr_en && (state_q == CH_IDLE);
  assign stat_wr  = wr_en && (wr_off == OFF_STATUS);

  always_comb begin
    state_nx = state_q;
    start_nx = 1'b0;
    rej_set  = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (start_wr) begin
          if (dma_len != '0) begin
            state_nx = CH_BUSY;
            start_nx = 1'b1;
          end else begin
            rej_set = 1'b1;
          end
        end
      end
      CH_BUSY: begin
        rej_set  = start_wr;
        done_set = dma_done;
        err_set  = dma_err;
        if (dma_done || dma_err) state_nx = CH_IDLE;
      end
      default: state_nx = CH_IDLE;
    endcase
  end

  assign irq_set = done_set | err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      dma_start <= 1'b0;
    end else begin
      state_q   <= state_nx;
      dma_start <= start_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_dir  <= 1'b0;
      dma_addr <= '0;
      dma_len  <= '0;
    end else if (cfg_wr) begin
      case (wr_off)
        OFF_CTRL:    dma_dir         <= wr_data[CTRL_DIR];
        OFF_ADDR_LO: dma_addr[31:0]  <= wr_data;
        OFF_ADDR_HI: dma_addr[63:32] <= wr_data;
        OFF_LEN:     dma_len         <= wr_data;
        default: ;
      endcase
    end
  end

  // Sticky bits: a hardware set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      done_q <= (done_q & ~(stat_wr & wr_data[STAT_DONE])) | done_set;
      err_q  <= (err_q  & ~(stat_wr & wr_data[STAT_ERR]))  | err_set;
      rej_q  <= (rej_q  & ~(stat_wr & wr_data[STAT_REJ]))  | rej_set;
    end
  end

  assign status = {rej_q, err_q, done_q, (state_q == CH_BUSY)};

endmodule

// File: rtl/bar0_dma_regs.sv
// BAR0 register block for the DMA engine: address decode, per-channel
// register instances, global interrupt registers and the read path.
module bar0_dma_regs
  import bar0_regs_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_rst_n,
  input  logic                 bar0_wr,
  input  logic [15:0]          bar0_wr_addr,
  input  logic [31:0]          bar0_wr_data,
  input  logic                 bar0_rd,
  input  logic [15:0]          bar0_rd_addr,
  output logic                 bar0_rd_valid,
  output logic [31:0]          bar0_rd_data,
  output logic [NUM_CH-1:0]    dma_start,
  output logic [NUM_CH-1:0]    dma_dir,
  output logic [NUM_CH*64-1:0] dma_addr,
  output logic [NUM_CH*32-1:0] dma_len,
  input  logic [NUM_CH-1:0]    dma_done,
  input  logic [NUM_CH-1:0]    dma_err,
  output logic                 irq
);

  logic                wr_in_ch, rd_in_ch;
  logic [CH_IDX_W-1:0] wr_ch, rd_ch;
  logic [NUM_CH-1:0]   ch_wr_en;
  logic [NUM_CH-1:0]   ch_irq_set;
  logic [3:0]          ch_status [NUM_CH];
  logic [31:0]         irq_en_q;
  logic [NUM_CH-1:0]   irq_stat_q;
  logic [NUM_CH-1:0]   irq_stat_clr;
  logic                irq_q;
  logic [31:0]         rd_mux;
  logic [31:0]         rd_data_p1;
  logic                vld_p1;

  assign wr_in_ch = in_ch_region(bar0_wr_addr);
  assign rd_in_ch = in_ch_region(bar0_rd_addr);
  assign wr_ch    = ch_index(bar0_wr_addr);
  assign rd_ch    = ch_index(bar0_rd_addr);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_wr_en[n] = bar0_wr && wr_in_ch && (wr_ch == CH_IDX_W'(n));

    dma_ch_regs u_ch (
      .clk       (pcie_clk),
      .rst_n     (pcie_rst_n),
      .wr_en     (ch_wr_en[n]),
      .wr_off    (bar0_wr_addr[4:0]),
      .wr_data   (bar0_wr_data),
      .dma_done  (dma_done[n]),
      .dma_err   (dma_err[n]),
      .dma_start (dma_start[n]),
      .dma_dir   (dma_dir[n]),
      .dma_addr  (dma_addr[64*n +: 64]),
      .dma_len   (dma_len[32*n +: 32]),
      .status    (ch_status[n]),
      .irq_set   (ch_irq_set[n])
    );
  end

  assign irq_stat_clr = (bar0_wr && bar0_wr_addr == REG_IRQ_STAT) ?
                        bar0_wr_data[NUM_CH-1:0] : '0;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (bar0_wr && bar0_wr_addr == REG_IRQ_EN) irq_en_q <= bar0_wr_data;
      irq_stat_q <= (irq_stat_q & ~irq_stat_clr) | ch_irq_set;
      irq_q      <= |(irq_stat_q & irq_en_q[NUM_CH-1:0]);
    end
  end

  assign irq = irq_q;

  // Read mux samples state before this cycle's write lands.
  always_comb begin
    rd_mux = '0;
    if (rd_in_ch) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (rd_ch == CH_IDX_W'(n)) begin
          case (bar0_rd_addr[4:0])
            OFF_CTRL:    rd_mux[CTRL_DIR] = dma_dir[n];
            OFF_ADDR_LO: rd_mux = dma_addr[64*n +: 32];
            OFF_ADDR_HI: rd_mux = dma_addr[64*n+32 +: 32];
            OFF_LEN:     rd_mux = dma_len[32*n +: 32];
            OFF_STATUS:  rd_mux = {28'b0, ch_status[n]};
            default: ;
          endcase
        end
      end
    end else begin
      case (bar0_rd_addr)
        REG_IRQ_EN:   rd_mux = irq_en_q;
        REG_IRQ_STAT: rd_mux = 32'(irq_stat_q);
        REG_VERSION:  rd_mux = VERSION;
        default: ;
      endcase
    end
  end

  // Stage p1: registered read response
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1     <= bar0_rd;
      rd_data_p1 <= bar0_rd ? rd_mux : '0;
    end
  end

  assign bar0_rd_valid = vld_p1;
  assign bar0_rd_data  = rd_data_p1;

endmodule

// File: tb/tb_bar0_dma_regs.sv
// Randomized bench for bar0_dma_regs against a register-map level model,
// plus directed sequences for the start/reject/irq/reset scenarios.
module tb_bar0_dma_regs;

  localparam int          NUM_CH  = 4;
  localparam logic [31:0] VERSION = 32'h0002_0000;

  logic                 pcie_clk = 1'b0;
  logic                 pcie_rst_n = 1'b0;
  logic                 bar0_wr = 1'b0;
  logic [15:0]          bar0_wr_addr = '0;
  logic [31:0]          bar0_wr_data = '0;
  logic                 bar0_rd = 1'b0;
  logic [15:0]          bar0_rd_addr = '0;
  logic                 bar0_rd_valid;
  logic [31:0]          bar0_rd_data;
  logic [NUM_CH-1:0]    dma_start;
  logic [NUM_CH-1:0]    dma_dir;
  logic [NUM_CH*64-1:0] dma_addr;
  logic [NUM_CH*32-1:0] dma_len;
  logic [NUM_CH-1:0]    dma_done = '0;
  logic [NUM_CH-1:0]    dma_err = '0;
  logic                 irq;

  always #4 pcie_clk = ~pcie_clk;

  bar0_dma_regs #(.NUM_CH(NUM_CH), .VERSION(VERSION)) dut (
    .pcie_clk      (pcie_clk),
    .pcie_rst_n    (pcie_rst_n),
    .bar0_wr       (bar0_wr),
    .bar0_wr_addr  (bar0_wr_addr),
    .bar0_wr_data  (bar0_wr_data),
    .bar0_rd       (bar0_rd),
    .bar0_rd_addr  (bar0_rd_addr),
    .bar0_rd_valid (bar0_rd_valid),
    .bar0_rd_data  (bar0_rd_data),
    .dma_start     (dma_start),
    .dma_dir       (dma_dir),
    .dma_addr      (dma_addr),
    .dma_len       (dma_len),
    .dma_done      (dma_done),
    .dma_err       (dma_err),
    .irq           (irq)
  );

  int nvec = 0;
  int miscompares = 0;

  // Reference model: the register map as the host sees it.
  logic              m_busy [NUM_CH];
  logic              m_dir  [NUM_CH];
  logic              m_done [NUM_CH];
  logic              m_err  [NUM_CH];
  logic              m_rej  [NUM_CH];
  logic [63:0]       m_addr [NUM_CH];
  logic [31:0]       m_len  [NUM_CH];
  logic [31:0]       m_ien;
  logic [NUM_CH-1:0] m_istat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_busy[c] = 0; m_dir[c] = 0; m_done[c] = 0; m_err[c] = 0; m_rej[c] = 0;
      m_addr[c] = '0; m_len[c] = '0;
    end
    m_ien = '0;
    m_istat = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    int ch;
    if (a < 16'h0100) begin
      ch = int'(a) / 32;
      if (ch >= NUM_CH) return 32'h0;
      case (int'(a) % 32)
        'h00: return {30'b0, m_dir[ch], 1'b0};
        'h04: return m_addr[ch][31:0];
        'h08: return m_addr[ch][63:32];
        'h0C: return m_len[ch];
        'h10: return {28'b0, m_rej[ch], m_err[ch], m_done[ch], m_busy[ch]};
        default: return 32'h0;
      endcase
    end
    case (a)
      16'h0100: return m_ien;
      16'h0104: return 32'(m_istat);
      16'h0108: return VERSION;
      default:  return 32'h0;
    endcase
  endfunction

  // One clock: drive inputs, step the model, check every output after the edge.
  task automatic cycle(input logic wr, input logic [15:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [15:0] ra,
                       input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] er);
    logic [31:0]       exp_rd;
    logic              exp_irq;
    logic [NUM_CH-1:0] exp_start;
    logic [NUM_CH-1:0] set_istat;
    bar0_wr = wr; bar0_wr_addr = wa; bar0_wr_data = wd;
    bar0_rd = rd; bar0_rd_addr = ra;
    dma_done = dn; dma_err = er;

    exp_rd    = rd ? m_read(ra) : 32'h0;
    exp_irq   = |(m_istat & m_ien[NUM_CH-1:0]);
    exp_start = '0;
    set_istat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic hit;
      logic pre_busy;
      int   off;
      hit      = wr && (wa < 16'h0100) && (int'(wa) / 32 == c);
      off      = int'(wa) % 32;
      pre_busy = m_busy[c];
      if (hit && off == 'h10) begin
        if (wd[1]) m_done[c] = 0;
        if (wd[2]) m_err[c] = 0;
        if (wd[3]) m_rej[c] = 0;
      end
      if (pre_busy) begin
        if (hit && off == 0 && wd[0]) m_rej[c] = 1;
        if (dn[c] || er[c]) begin
          if (dn[c]) m_done[c] = 1;
          if (er[c]) m_err[c] = 1;
          m_busy[c] = 0;
          set_istat[c] = 1;
        end
      end else if (hit) begin
        case (off)
          'h00: begin
            m_dir[c] = wd[1];
            if (wd[0]) begin
              if (m_len[c] != 0) begin m_busy[c] = 1; exp_start[c] = 1; end
              else m_rej[c] = 1;
            end
          end
          'h04: m_addr[c][31:0]  = wd;
          'h08: m_addr[c][63:32] = wd;
          'h0C: m_len[c] = wd;
          default: ;
        endcase
      end
    end
    if (wr && wa == 16'h0104) m_istat = m_istat & ~wd[NUM_CH-1:0];
    m_istat = m_istat | set_istat;
    if (wr && wa == 16'h0100) m_ien = wd;

    @(posedge pcie_clk);
    #1;
    chk("rd_valid", 64'(bar0_rd_valid), 64'(rd));
    chk("rd_data", 64'(bar0_rd_data), 64'(exp_rd));
    chk("irq", 64'(irq), 64'(exp_irq));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("start%0d", c), 64'(dma_start[c]), 64'(exp_start[c]));
      chk($sformatf("dir%0d", c), 64'(dma_dir[c]), 64'(m_dir[c]));
      chk($sformatf("addr%0d", c), dma_addr[64*c +: 64], m_addr[c]);
      chk($sformatf("len%0d", c), 64'(dma_len[32*c +: 32]), 64'(m_len[c]));
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0, 16'h0, '0, '0);
  endtask

  task automatic rd_reg(input logic [15:0] a);
    cycle(1'b0, 16'h0, 32'h0, 1'b1, a, '0, '0);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, '0, '0);
  endtask

  // Reset away from the clock edge; outputs must drop without a clock.
  task automatic do_reset();
    pcie_rst_n = 1'b0;
    bar0_wr = 0; bar0_rd = 0; dma_done = '0; dma_err = '0;
    #1;
    model_reset();
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_start", 64'(dma_start), 64'h0);
    chk("rst_rd_valid", 64'(bar0_rd_valid), 64'h0);
    chk("rst_rd_data", 64'(bar0_rd_data), 64'h0);
    chk("rst_dir", 64'(dma_dir), 64'h0);
    chk("rst_addr0", dma_addr[63:0], 64'h0);
    chk("rst_len", 64'(dma_len[63:0]), 64'h0);
    @(posedge pcie_clk);
    #1;
    pcie_rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    int c;
    int o;
    if ($urandom_range(0, 9) < 7) begin
      c = $urandom_range(0, NUM_CH);
      o = $urandom_range(0, 5);
      return 16'(c * 32 + o * 4);
    end
    case ($urandom_range(0, 3))
      0:       return 16'h0100;
      1:       return 16'h0104;
      2:       return 16'h0108;
      default: return 16'h0200;
    endcase
  endfunction

  initial begin
    model_reset();
    #10;
    do_reset();
    idle();

    // Program ch1 and start it
    wr_reg(16'h0024, 32'h1000_0000);
    wr_reg(16'h0028, 32'h0000_0001);
    wr_reg(16'h002C, 32'h0000_0400);
    wr_reg(16'h0020, 32'h0000_0002);
    wr_reg(16'h0020, 32'h0000_0003);
    chk("r36_start_pulse", 64'(dma_start[1]), 64'h1);
    idle();
    chk("r36_start_single", 64'(dma_start[1]), 64'h0);
    chk("r36_addr", dma_addr[127:64], 64'h1_1000_0000);
    chk("r36_len", 64'(dma_len[63:32]), 64'h400);
    chk("r36_dir", 64'(dma_dir[1]), 64'h1);
    rd_reg(16'h0030);
    chk("r36_status", 64'(bar0_rd_data), 64'h1);

    // Restart and LEN rewrite while busy
    wr_reg(16'h0020, 32'h0000_0001);
    chk("r37_no_pulse", 64'(dma_start[1]), 64'h0);
    wr_reg(16'h002C, 32'h0000_0800);
    rd_reg(16'h002C);
    chk("r37_len", 64'(bar0_rd_data), 64'h400);
    rd_reg(16'h0030);
    chk("r37_status", 64'(bar0_rd_data), 64'h9);

    // Completion raises irq; W1C drops it
    wr_reg(16'h0030, 32'h0000_0008);
    wr_reg(16'h0100, 32'h0000_0002);
    cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 4'b0010, 4'b0000);
    rd_reg(16'h0030);
    chk("r38_status", 64'(bar0_rd_data), 64'h2);
    rd_reg(16'h0104);
    chk("r38_irq_stat", 64'(bar0_rd_data), 64'h2);
    chk("r38_irq_high", 64'(irq), 64'h1);
    wr_reg(16'h0104, 32'h0000_0002);
    idle();
    chk("r38_irq_low", 64'(irq), 64'h0);

    // Error set collides with W1C of the same IRQ_STAT bit
    wr_reg(16'h000C, 32'h0000_0010);
    wr_reg(16'h0000, 32'h0000_0001);
    cycle(1'b1, 16'h0104, 32'h0000_0001, 1'b0, 16'h0, 4'b0000, 4'b0001);
    rd_reg(16'h0104);
    chk("r39_set_wins", 64'(bar0_rd_data[0]), 64'h1);
    rd_reg(16'h0010);
    chk("r39_ch0_status", 64'(bar0_rd_data), 64'h4);

    // VERSION and an unmapped address
    rd_reg(16'h0108);
    chk("r40_ver_valid", 64'(bar0_rd_valid), 64'h1);
    chk("r40_version", 64'(bar0_rd_data), 64'h0002_0000);
    rd_reg(16'h0200);
    chk("r40_unmapped", 64'(bar0_rd_data), 64'h0);
    idle();
    chk("r40_valid_low", 64'(bar0_rd_valid), 64'h0);

    // Reset during a ch2 transfer while irq and dma_start are high
    wr_reg(16'h0100, 32'h0000_000F);
    idle();
    chk("r41_irq_before", 64'(irq), 64'h1);
    wr_reg(16'h004C, 32'h0000_0100);
    wr_reg(16'h0040, 32'h0000_0001);
    chk("r41_start_before", 64'(dma_start[2]), 64'h1);
    do_reset();
    cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 4'b0100, 4'b0000);
    rd_reg(16'h0050);
    chk("r41_status", 64'(bar0_rd_data), 64'h0);
    idle();
    chk("r41_irq", 64'(irq), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic              wr;
      logic              rd;
      logic [15:0]       wa;
      logic [15:0]       ra;
      logic [31:0]       wd;
      logic [NUM_CH-1:0] dn;
      logic [NUM_CH-1:0] er;
      if ($urandom_range(0, 499) == 0) do_reset();
      wr = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 1) == 1;
      wa = rand_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      wd = $urandom;
      if (wa < 16'h0100 && wa[4:0] == 5'h00) wd = 32'($urandom_range(0, 3));
      if (wa < 16'h0100 && wa[4:0] == 5'h0C && $urandom_range(0, 3) == 0) wd = 32'h0;
      for (int c = 0; c < NUM_CH; c++) begin
        dn[c] = $urandom_range(0, 7) == 0;
        er[c] = $urandom_range(0, 11) == 0;
      end
      cycle(wr, wa, wd, rd, ra, dn, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule

// File: doc/bar0_dma_regs.md
BAR0_DMA_REGS -- requirements
Module: bar0_dma_regs

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter VERSION, default 32'h0002_0000, value returned by the VERSION register.
REQ-003 SHALL have input pcie_clk, 1 bit: the single clock (125 MHz).
REQ-004 SHALL have input pcie_rst_n, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have input bar0_wr, 1 bit: write strobe, one cycle per write.
REQ-006 SHALL have input bar0_wr_addr, 16 bits: byte address of the write.
REQ-007 SHALL have input bar0_wr_data, 32 bits: write data.
REQ-008 SHALL have input bar0_rd, 1 bit: read strobe.
REQ-009 SHALL have input bar0_rd_addr, 16 bits: byte address of the read.
REQ-010 SHALL have output bar0_rd_valid, 1 bit: read data valid.
REQ-011 SHALL have output bar0_rd_data, 32 bits: read data.
REQ-012 SHALL have output dma_start, NUM_CH bits: per-channel one-cycle start pulse.
REQ-013 SHALL have output dma_dir, NUM_CH bits: per-channel direction, 0 = card-to-host write, 1 = host-to-card read.
REQ-014 SHALL have output dma_addr, NUM_CH*64 bits: per-channel host address, channel n at bits [64n+63:64n].
REQ-015 SHALL have output dma_len, NUM_CH*32 bits: per-channel byte length, channel n at bits [32n+31:32n].
REQ-016 SHALL have input dma_done, NUM_CH bits: per-channel completion pulse from the engine.
REQ-017 SHALL have input dma_err, NUM_CH bits: per-channel error pulse from the engine.
REQ-018 SHALL have output irq, 1 bit: level interrupt request.

Function
REQ-019 Register map SHALL be: channel n at base 0x20*n, with offsets CTRL 0x00, ADDR_LO 0x04, ADDR_HI 0x08, LEN 0x0C, STATUS 0x10; globals IRQ_EN 0x100, IRQ_STAT 0x104, VERSION 0x108.
REQ-020 CTRL SHALL decode as: bit0 START (write-1 pulse, reads 0), bit1 DIR (R/W).
REQ-021 STATUS SHALL decode as: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bit3 REJ (W1C, start rejected).
REQ-022 Each channel SHALL run a state machine IDLE -> BUSY -> IDLE.
- IDLE: a START write with LEN != 0 enters BUSY and asserts dma_start for exactly one cycle, the cycle after the write.
- BUSY: dma_done sets DONE and returns to IDLE; dma_err sets ERR and returns to IDLE; both together set both bits.
REQ-023 START while BUSY, or with LEN == 0, SHALL be ignored and SHALL set REJ.
REQ-024 While BUSY, writes to ADDR_LO, ADDR_HI, LEN and DIR SHALL be ignored, so dma_addr, dma_len and dma_dir stay stable for the whole transfer.
REQ-025 dma_done and dma_err SHALL be ignored while a channel is in IDLE.
REQ-026 IRQ_STAT bit n SHALL set on channel n entering DONE or ERR, SHALL be W1C, and bits above NUM_CH-1 SHALL read 0.
REQ-027 If a hardware set and a W1C clear hit the same bit in the same cycle, the set SHALL win (applies to STATUS and IRQ_STAT).
REQ-028 irq SHALL equal |(IRQ_STAT & IRQ_EN[NUM_CH-1:0]), registered, one cycle after the status change.
REQ-029 Reads SHALL have a latency of 1: bar0_rd_valid high the cycle after bar0_rd; the data is 0 when bar0_rd_valid is low or the address is unmapped.
REQ-030 Writes to unmapped addresses and to channels >= NUM_CH SHALL have no effect.
REQ-031 A simultaneous read and write to the same register SHALL return the pre-write value.

Reset
REQ-032 While pcie_rst_n is low, all registers and all outputs SHALL be 0 and every channel SHALL be in IDLE; irq and dma_start SHALL deassert immediately (asynchronously).
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer, and no DONE SHALL be recorded afterwards.

Structure
REQ-034 A shared package bar0_regs_pkg SHALL hold the register offsets, the channel stride, the CTRL/STATUS bit positions and the channel state enum.
REQ-035 The per-channel registers and state machine SHALL live in sub-module dma_ch_regs, instantiated NUM_CH times via generate; the top level holds address decode, the globals, the read mux and irq.

Verification
REQ-036 Write ch1 ADDR_LO=0x1000_0000, ADDR_HI=0x1, LEN=0x400, DIR=1, then START -> dma_start[1] is high for 1 cycle, dma_addr ch1 = 0x1_1000_0000, dma_len = 0x400, dma_dir[1] = 1, STATUS = 0x1.
REQ-037 With ch1 BUSY, write START again and LEN=0x800 -> no pulse, LEN still 0x400, STATUS = 0x9.
REQ-038 IRQ_EN=0x2, then pulse dma_done[1] -> STATUS = 0x2, IRQ_STAT = 0x2, irq high; write 0x2 to IRQ_STAT -> irq low the next cycle.
REQ-039 In the same cycle, dma_err[0] fires on a BUSY ch0 and a W1C of IRQ_STAT bit0 is written -> bit0 remains 1.
REQ-040 Read VERSION and unmapped address 0x200 -> bar0_rd_valid one cycle later, data 0x0002_0000 and 0 respectively.
REQ-041 Assert pcie_rst_n low during a ch2 BUSY transfer, release it, then pulse dma_done[2] -> STATUS = 0, irq = 0.
